// File: rtl/toggle_pulse_gen.sv
// Synchronises and debounces a raw button, emitting one registered T pulse per accepted press plus optional auto-repeat.
// Latency: a press is accepted DEBOUNCE_CYCLES+2 edges after it is first sampled; there is no backpressure and T is a one-cycle pulse.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 0,
  parameter int REPEAT_PERIOD   = 8,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_in,
  output logic               T,
  output logic               btn_level,
  output logic [COUNT_W-1:0] press_count
);

  localparam int CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = REPEAT_DELAY + REPEAT_PERIOD - 1;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] R_FIRST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(RMAX);
  localparam logic [RW-1:0] R_RELOAD = RW'(REPEAT_DELAY);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [1:0]         sync;
  logic               btn_s;
  logic [CW-1:0]      cnt, cnt_n;
  logic [RW-1:0]      rcnt, rcnt_n;
  logic               t_n, lvl_n;
  logic [COUNT_W-1:0] pc_n;

  assign btn_s = sync[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= '0;
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      T           <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      sync        <= {sync[0], btn_in};
      state       <= state_n;
      cnt         <= cnt_n;
      rcnt        <= rcnt_n;
      T           <= t_n;
      btn_level   <= lvl_n;
      press_count <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rcnt_n  = rcnt;
    t_n     = 1'b0;
    lvl_n   = btn_level;
    pc_n    = press_count;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_DB;
          cnt_n   = '0;
        end
      end
      PRESS_DB: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = HELD;
          t_n     = 1'b1;
          lvl_n   = 1'b1;
          pc_n    = press_count + 1'b1;
          rcnt_n  = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_DB;
          cnt_n   = '0;
        end else if (REPEAT_DELAY > 0) begin
          // rcnt runs up to R_LAST and reloads to R_RELOAD, so it never wraps
          if (rcnt == R_FIRST || rcnt == R_LAST) begin
            t_n  = 1'b1;
            pc_n = press_count + 1'b1;
          end
          rcnt_n = (rcnt == R_LAST) ? R_RELOAD : rcnt + 1'b1;
        end
      end
      RELEASE_DB: begin
        if (btn_s) begin
          state_n = HELD;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          lvl_n   = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench: default, auto-repeat and narrow-counter instances of toggle_pulse_gen, plus a T flip-flop load.
module tb_toggle_pulse_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn0 = 1'b0, btn_r = 1'b0, btn_w = 1'b0;
  logic       t0, lvl0, t_r, lvl_r, t_w, lvl_w;
  logic [7:0] pc0, pc_r;
  logic [1:0] pc_w;
  logic       q;
  int         n_cmp = 0, n_bad = 0;
  int         np0 = 0, npr = 0;
  int         base;
  logic       exp_t;

  always #5 clk = ~clk;

  toggle_pulse_gen dut (
    .clk(clk), .reset(reset), .btn_in(btn0),
    .T(t0), .btn_level(lvl0), .press_count(pc0)
  );

  toggle_pulse_gen #(.REPEAT_DELAY(10), .REPEAT_PERIOD(4)) dut_r (
    .clk(clk), .reset(reset), .btn_in(btn_r),
    .T(t_r), .btn_level(lvl_r), .press_count(pc_r)
  );

  toggle_pulse_gen #(.COUNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .btn_in(btn_w),
    .T(t_w), .btn_level(lvl_w), .press_count(pc_w)
  );

  // Downstream T flip-flop
  always @(posedge clk) begin
    if (reset) q <= 1'b0;
    else if (t_w) q <= ~q;
  end

  always @(negedge clk) begin
    if (t0) np0 = np0 + 1;
    if (t_r) npr = npr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    step(2);
    check("rst_T", t0, 0);
    check("rst_lvl", lvl0, 0);
    check("rst_pc", pc0, 0);
    reset = 1'b0;

    // 3-cycle bounce from idle
    base = np0;
    btn0 = 1'b1; step(3); btn0 = 1'b0; step(10);
    check("bounce_pc", pc0, 0);
    check("bounce_pulses", np0 - base, 0);
    check("bounce_lvl", lvl0, 0);

    // clean press: pulse after edge 6
    btn0 = 1'b1;
    step(6);
    check("press_T_e5", t0, 0);
    check("press_lvl_e5", lvl0, 0);
    step(1);
    check("press_T_e6", t0, 1);
    check("press_lvl_e6", lvl0, 1);
    check("press_pc_e6", pc0, 1);
    step(1);
    check("press_T_e7", t0, 0);
    step(12);
    check("press_pulses", np0 - base, 1);

    // 3-cycle low glitch while held
    btn0 = 1'b0; step(3); btn0 = 1'b1;
    check("glitch_lvl_mid", lvl0, 1);
    step(8);
    check("glitch_lvl", lvl0, 1);
    check("glitch_pc", pc0, 1);
    check("glitch_pulses", np0 - base, 1);

    // release
    btn0 = 1'b0;
    step(6);
    check("rel_lvl_e5", lvl0, 1);
    step(1);
    check("rel_lvl_e6", lvl0, 0);
    step(4);
    check("rel_pulses", np0 - base, 1);
    check("rel_pc", pc0, 1);

    // reset on the acceptance edge
    btn0 = 1'b1;
    step(6);
    reset = 1'b1;
    step(1);
    check("midrst_T", t0, 0);
    check("midrst_pc", pc0, 0);
    check("midrst_lvl", lvl0, 0);
    reset = 1'b0;
    step(7);
    check("after_rst_T", t0, 1);
    check("after_rst_pc", pc0, 1);
    btn0 = 1'b0;
    step(10);

    // auto-repeat: held 30 cycles, pulses at edges 6,16,20,24,28
    base = npr;
    btn_r = 1'b1;
    for (int e = 0; e < 40; e++) begin
      step(1);
      exp_t = (e == 6 || e == 16 || e == 20 || e == 24 || e == 28);
      check($sformatf("rep_T_e%0d", e), t_r, exp_t);
      if (e == 29) btn_r = 1'b0;
    end
    check("rep_pulses", npr - base, 5);
    check("rep_pc", pc_r, 5);
    check("rep_lvl", lvl_r, 0);

    // 2-bit wrap and TFF toggling
    reset = 1'b1; step(2); reset = 1'b0;
    check("tff_rst_q", q, 0);
    for (int i = 0; i < 5; i++) begin
      btn_w = 1'b1;
      step(10);
      check($sformatf("wrap_pc_%0d", i), pc_w, (i + 1) % 4);
      check($sformatf("tff_q_%0d", i), q, (i + 1) % 2);
      btn_w = 1'b0;
      step(10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
